// File: rtl/syn_hazard_pkg.sv
// Shared constants and types for the load-use hazard resolver.
// Forwarding-select encodings and the stall FSM state type.
package syn_hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_DM  = 2'd2;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

endpackage

// File: rtl/syn_hazard_resolver_fwd_sel.sv
// Per-operand forwarding select: EX result beats DM result; a load still
// in EX cannot forward (its data is not ready yet).
module syn_fwd_sel
    import syn_hazard_pkg::*;
(
    input  logic       uses,
    input  logic       ex_col,
    input  logic       dm_col,
    input  logic       ex_is_load,
    output logic [1:0] sel
);

    // Priority select: EX (non-load) first, then DM, else regfile.
    always_comb begin
        sel = FWD_REG;
        if (uses) begin
            if (ex_col && !ex_is_load) begin
                sel = FWD_EX;
            end else if (dm_col) begin
                sel = FWD_DM;
            end
        end
    end

endmodule

// File: rtl/syn_hazard_resolver.sv
// Load-use hazard resolver for the five-stage pipeline (ID stage).
// Converts detector collision flags into forwarding selects and a one-cycle
// load-use stall; keeps a load history in step with the detector.
// Optional macro SYN_STALL_STATS_EN enables a saturating stall counter.
module syn_hazard_resolver
    import syn_hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             id_is_load,
    input  logic             id_uses_a,
    input  logic             id_uses_b,
    input  logic             ex_collision_a,
    input  logic             dm_collision_a,
    input  logic             ex_collision_b,
    input  logic             dm_collision_b,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_count
);

    state_t state;
    state_t state_next;
    logic   ex_is_load;
    logic   dm_is_load;
    logic   hazard;

    assign hazard = ex_is_load && ((ex_collision_a && id_uses_a) ||
                                   (ex_collision_b && id_uses_b));

    // Next-state and stall decode; a stall is only raised from RUN.
    always_comb begin
        state_next = state;
        stalled    = 1'b0;
        case (state)
            RUN: begin
                stalled = en && hazard;
                if (stalled) begin
                    state_next = BUBBLE;
                end
            end
            BUBBLE: begin
                if (en) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State and load history; a stall squashes the ID slot into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            ex_is_load <= 1'b0;
            dm_is_load <= 1'b0;
        end else if (en) begin
            state      <= state_next;
            ex_is_load <= stalled ? 1'b0 : id_is_load;
            dm_is_load <= ex_is_load;
        end
    end

`ifdef SYN_STALL_STATS_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of stall cycles (stalled already implies en).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stalled && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall_count = cnt;
`else
    assign stall_count = '0;
`endif

    syn_fwd_sel u_fwd_a (
        .uses       (id_uses_a),
        .ex_col     (ex_collision_a),
        .dm_col     (dm_collision_a),
        .ex_is_load (ex_is_load),
        .sel        (fwd_sel_a)
    );

    syn_fwd_sel u_fwd_b (
        .uses       (id_uses_b),
        .ex_col     (ex_collision_b),
        .dm_col     (dm_collision_b),
        .ex_is_load (ex_is_load),
        .sel        (fwd_sel_b)
    );

endmodule

// File: tb/tb_syn_hazard_resolver.sv
// Self-checking bench for syn_hazard_resolver: vector table plus
// hand-written reset-during-stall sequences, checked through a queue.
module tb_syn_hazard_resolver;

    localparam int unsigned CNT_W = 2;
`ifdef SYN_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             id_is_load;
    logic             id_uses_a;
    logic             id_uses_b;
    logic             ex_collision_a;
    logic             dm_collision_a;
    logic             ex_collision_b;
    logic             dm_collision_b;
    logic [1:0]       fwd_sel_a;
    logic [1:0]       fwd_sel_b;
    logic             stalled;
    logic [CNT_W-1:0] stall_count;

    syn_hazard_resolver #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .id_is_load     (id_is_load),
        .id_uses_a      (id_uses_a),
        .id_uses_b      (id_uses_b),
        .ex_collision_a (ex_collision_a),
        .dm_collision_a (dm_collision_a),
        .ex_collision_b (ex_collision_b),
        .dm_collision_b (dm_collision_b),
        .fwd_sel_a      (fwd_sel_a),
        .fwd_sel_b      (fwd_sel_b),
        .stalled        (stalled),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         ld;
        bit         ua;
        bit         ub;
        bit         exa;
        bit         dma;
        bit         exb;
        bit         dmb;
        logic [1:0] fa;
        logic [1:0] fb;
        bit         st;
        int         nstall;
    } vec_t;

    typedef struct {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[14];

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        int sat;
        sat = (1 << CNT_W) - 1;
        if (!STATS) return '0;
        return (n > sat) ? CNT_W'(sat) : CNT_W'(n);
    endfunction

    task automatic drive(input bit e, input bit ld, input bit ua, input bit ub,
                         input bit exa, input bit dma, input bit exb, input bit dmb);
        en = e; id_is_load = ld; id_uses_a = ua; id_uses_b = ub;
        ex_collision_a = exa; dm_collision_a = dma;
        ex_collision_b = exb; dm_collision_b = dmb;
    endtask

    task automatic expect_out(input logic [1:0] fa, input logic [1:0] fb,
                              input logic st, input int n);
        exp_t e;
        e.fa = fa; e.fb = fb; e.st = st; e.cnt = exp_cnt(n);
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        tests++;
        if (fwd_sel_a !== e.fa || fwd_sel_b !== e.fb ||
            stalled !== e.st || stall_count !== e.cnt) begin
            fails++;
            $display("FAIL %s: got fa=%0d fb=%0d st=%0b cnt=%0d, want fa=%0d fb=%0d st=%0b cnt=%0d",
                     tag, fwd_sel_a, fwd_sel_b, stalled, stall_count,
                     e.fa, e.fb, e.st, e.cnt);
        end
    endtask

    initial begin
        //          en ld ua ub exa dma exb dmb  fa    fb    st nstall
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0}; // idle
        vecs[1]  = '{1, 1, 1, 0, 1, 1, 0, 0, 2'd1, 2'd0, 0, 0}; // EX beats DM
        vecs[2]  = '{1, 0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 1, 0}; // load-use B
        vecs[3]  = '{1, 0, 0, 1, 0, 0, 0, 1, 2'd0, 2'd2, 0, 1}; // bubble, DM fwd
        vecs[4]  = '{1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1}; // load enters
        vecs[5]  = '{1, 1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 1}; // col, unused A
        vecs[6]  = '{0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 1}; // hazard, en=0
        vecs[7]  = '{1, 0, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 1, 1}; // en=1: stall once
        vecs[8]  = '{1, 0, 1, 0, 0, 1, 0, 0, 2'd2, 2'd0, 0, 2}; // bubble, DM fwd
        vecs[9]  = '{1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2}; // load r1
        vecs[10] = '{1, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 1, 2}; // load r2 <- r1
        vecs[11] = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd2, 2'd0, 0, 3}; // bubble
        vecs[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 1, 3}; // use r2
        vecs[13] = '{1, 0, 0, 1, 0, 0, 0, 1, 2'd0, 2'd2, 0, 4}; // bubble, saturated

        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        expect_out(2'd0, 2'd0, 1'b0, 0);
        check_out("reset");
        #10 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].ld, vecs[i].ua, vecs[i].ub,
                  vecs[i].exa, vecs[i].dma, vecs[i].exb, vecs[i].dmb);
            expect_out(vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].nstall);
            #2;
            check_out($sformatf("vec%0d", i));
        end

        // Asynchronous reset with a load in EX and a live hazard.
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        expect_out(2'd0, 2'd0, 1'b1, 4);
        #2 check_out("pre_reset_stall");
        rst_n = 1'b0;
        expect_out(2'd1, 2'd0, 1'b0, 0);
        #1 check_out("async_clear");
        @(negedge clk);
        rst_n = 1'b1;
        expect_out(2'd1, 2'd0, 1'b0, 0);
        #2 check_out("post_reset_first");

        // Reset asserted while in BUBBLE.
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        expect_out(2'd0, 2'd0, 1'b1, 0);
        #2 check_out("stall_before_bubble_reset");
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        expect_out(2'd0, 2'd0, 1'b0, 0);
        #1 check_out("reset_in_bubble");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        expect_out(2'd0, 2'd0, 1'b0, 0);
        #2 check_out("post_bubble_reset_first");
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0, 1, 0);
        expect_out(2'd0, 2'd0, 1'b1, 0);
        #2 check_out("run_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/syn_hazard_resolver.md
# syn_hazard_resolver

Consumer of the synchronous data-collision detector's flags: turns the per-operand EX/DM collision indications into forwarding-mux selects and a load-use stall for the five-stage pipeline. It also drives the `stalled` input that the detector uses to shift its own write-register history. It sits in the ID stage beside the detector. It keeps a load/no-load history that shifts in lock-step with the detector's write-register history.

## Interface

**Parameters**
- `CNT_W`, default 32: width of the stall statistics counter.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `en`, in, 1: pipeline enable. When low, all state holds.
- `id_is_load`, in, 1: the instruction now in ID is a load.
- `id_uses_a`, in, 1: the ID instruction reads operand A.
- `id_uses_b`, in, 1: the ID instruction reads operand B.
- `ex_collision_a`, in, 1: collision flag from the detector.
- `dm_collision_a`, in, 1: collision flag from the detector.
- `ex_collision_b`, in, 1: collision flag from the detector.
- `dm_collision_b`, in, 1: collision flag from the detector.
- `fwd_sel_a`, out, 2: operand A source. 0 = regfile, 1 = EX result, 2 = DM result.
- `fwd_sel_b`, out, 2: operand B source, same encoding.
- `stalled`, out, 1: load-use stall. Feeds the detector, holds PC and IF/ID, and inserts a bubble into ID/EX.
- `stall_count`, out, `CNT_W`: number of stall cycles (see Configuration).

## Operation

**History registers**
- `ex_is_load` and `dm_is_load` shift exactly as the detector shifts its write-register history.
- On each `clk` edge, with `en` high:
  - If `stalled`: `ex_is_load` ← 0 and `dm_is_load` ← `ex_is_load`.
  - Otherwise: `ex_is_load` ← `id_is_load` and `dm_is_load` ← `ex_is_load`.

**Load-use detection**
- `hazard` = `ex_is_load` && ((`ex_collision_a` && `id_uses_a`) || (`ex_collision_b` && `id_uses_b`)).

**FSM**
- States are `RUN` and `BUBBLE`.
- `stalled` = `en` && (state == `RUN`) && `hazard`.
- `RUN` → `BUBBLE` when `stalled`.
- `BUBBLE` → `RUN` on the next enabled edge, unconditionally.
- `stalled` is forced to 0 in `BUBBLE`. A stall therefore never lasts more than one cycle.

**Forwarding select** (per operand X ∈ {a, b})
- If `id_uses_x` = 0: select 0.
- Else if `ex_collision_x` && !`ex_is_load`: select 1. EX has priority over DM.
- Else if `dm_collision_x`: select 2.
- Else: select 0.
- During a stall, the select value is don't-care for correctness, but it is still computed by the same rule.

**Other rules**
- Register 0 is never flagged by the detector, so no special case is needed here.
- `en` low: FSM, history registers and counter all hold. `stalled` = 0. Selects remain combinational.

## Timing

- Selects and `stalled` are combinational from the current inputs and state. Zero-cycle latency.
- Load-use sequence:
  - Cycle N: load in EX, dependent instruction in ID. `stalled` = 1.
  - Cycle N+1: state is `BUBBLE`, the load is in DM, and `fwd_sel` = 2.
- Reset values:
  - state = `RUN`, `ex_is_load` = 0, `dm_is_load` = 0, `stall_count` = 0.
  - Hence `stalled` = 0 and both selects = 0 while `rst_n` is low.
- Reset asserted mid-stall: immediate return to `RUN` with cleared history. No stall on the first cycle after reset release.
- Back-to-back loads with a dependency (load r1; load r2 ← r1; use r2): each load-use pair gives exactly one bubble.

## Configuration

- `SYN_STALL_STATS_EN` defined:
  - `stall_count` increments on every cycle with `stalled` = 1.
  - It saturates at all-ones.
  - It resets to 0.
- Not defined: the counter logic is removed and `stall_count` is tied to 0.

## Structure

**Package `syn_hazard_pkg`**
- Constants `FWD_REG` = 2'd0, `FWD_EX` = 2'd1, `FWD_DM` = 2'd2.
- FSM state enum {`RUN`, `BUBBLE`}.

**Sub-module `syn_fwd_sel`**
- Per-operand select logic.
- Inputs: `uses`, `ex_col`, `dm_col`, `ex_is_load`. Output: `sel`.
- Instantiated twice (A and B).

## Test plan

- After reset, all collisions = 0 → `fwd_sel_a` = `fwd_sel_b` = 0, `stalled` = 0, `stall_count` = 0.
- Non-load in EX, with `ex_collision_a` = 1 and `dm_collision_a` = 1, `id_uses_a` = 1 → `fwd_sel_a` = 1 (EX priority), `stalled` = 0.
- Load in EX, `ex_collision_b` = 1, `id_uses_b` = 1 → `stalled` = 1 for exactly one cycle. Next cycle: `dm_collision_b` = 1 and `fwd_sel_b` = 2. `stall_count` = 1 with the macro, 0 without.
- Load in EX, `ex_collision_a` = 1 but `id_uses_a` = 0 → no stall, `fwd_sel_a` = 0.
- Same cycle as the previous case, raise `en` = 0 while a hazard is present → `stalled` = 0, state held. On `en` = 1 the stall occurs once.
- `rst_n` pulled low in `BUBBLE` → state = `RUN` and history cleared asynchronously. The first post-reset cycle has `stalled` = 0.
